// File: rtl/user_module_dffsr.sv
// rtl/user_module_dffsr.sv - D flip-flop with async set/reset plus Q observation pins
module user_module_dffsr (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CNT_W = 4;

  logic             clk;
  logic             data;
  logic             set_n;
  logic             rst_n;
  logic             set_eff_n;
  logic             q_q;
  logic             qdly_q;
  logic             chg;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_io_in;

  assign clk   = io_in[0];
  assign data  = io_in[1];
  assign set_n = io_in[2];
  assign rst_n = io_in[3];

  // Upper input pins are tester don't-cares and must never reach an output.
  assign unused_io_in = &{1'b0, io_in[7:4]};

  // Set only counts while reset is released. Releasing reset while set is
  // still low then produces a falling edge here, so the flop picks up the
  // set level instead of staying cleared until the next clock.
  assign set_eff_n = set_n | ~rst_n;

  // Core flop: reset beats set, set beats the clocked data.
  always_ff @(posedge clk or negedge rst_n or negedge set_eff_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (!set_eff_n) begin
      q_q <= 1'b1;
    end else begin
      q_q <= data;
    end
  end

  // One-edge delayed copy of q; set does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qdly_q <= 1'b0;
    end else begin
      qdly_q <= q_q;
    end
  end

  // A difference between q and its delayed copy marks a q change.
  assign chg = q_q ^ qdly_q;

  // Counter advances once per observed change and wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (chg) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Change counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign io_out = {cnt_q, chg, qdly_q, ~q_q, q_q};

endmodule

// File: tb/tb_user_module_dffsr.sv
// tb/tb_user_module_dffsr.sv - directed self-checking bench for user_module_dffsr
module tb_user_module_dffsr;

  logic       clk;
  logic       data;
  logic       set_n;
  logic       rst_n;
  logic [3:0] junk;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         n_checks;
  int         n_pass;

  assign io_in = {junk, rst_n, set_n, data, clk};

  user_module_dffsr dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scramble the don't-care pins away from the rising edge.
  always @(negedge clk) junk = 4'($urandom);

  function automatic logic [7:0] pins(input logic q, input logic qd, input logic [3:0] cnt);
    return {cnt, q ^ qd, qd, ~q, q};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: io_out=%b expected %b at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  logic       dv   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       qv   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       qdv  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] cntv [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    junk     = 4'($urandom);
    rst_n    = 1'b0;
    set_n    = 1'b1;
    data     = 1'b1;

    // Held in reset: clocks must not move anything.
    #1 check("reset_t0", io_out, pins(1'b0, 1'b0, 4'd0));
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_clk", io_out, pins(1'b0, 1'b0, 4'd0));
    end
    #1 rst_n = 1'b1;
    #1 check("reset_release_hold", io_out, pins(1'b0, 1'b0, 4'd0));
    @(posedge clk); #1;
    check("first_edge", io_out, pins(1'b1, 1'b0, 4'd0));
    @(posedge clk); #1;
    check("second_edge", io_out, pins(1'b1, 1'b1, 4'd1));

    // Async reset mid-cycle, then the data sequence.
    rst_n = 1'b0;
    #1 check("async_reset", io_out, pins(1'b0, 1'b0, 4'd0));
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = dv[i];
      @(posedge clk); #1;
      check($sformatf("seq_%0d", i), io_out, pins(qv[i], qdv[i], cntv[i]));
    end

    // Set pulse between edges with data=0.
    data = 1'b0;
    #1 set_n = 1'b0;
    #1 check("set_async", io_out, pins(1'b1, 1'b0, 4'd4));
    #1 set_n = 1'b1;
    #1 check("set_release_hold", io_out, pins(1'b1, 1'b0, 4'd4));
    @(posedge clk); #1;
    check("set_after_edge1", io_out, pins(1'b0, 1'b1, 4'd5));
    @(posedge clk); #1;
    check("set_after_edge2", io_out, pins(1'b0, 1'b0, 4'd6));

    // Set and reset together; reset released first.
    data = 1'b1;
    #1 begin set_n = 1'b0; rst_n = 1'b0; end
    #1 check("both_low", io_out, pins(1'b0, 1'b0, 4'd0));
    #1 rst_n = 1'b1;
    #1 check("set_still_low", io_out, pins(1'b1, 1'b0, 4'd0));
    #1 begin set_n = 1'b1; data = 1'b0; end
    #1 check("set_released_hold", io_out, pins(1'b1, 1'b0, 4'd0));
    @(posedge clk); #1;
    check("sample_after_set", io_out, pins(1'b0, 1'b1, 4'd1));

    // Toggle data each edge from a clean state; counter wraps past 15.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    data = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      data = ~data;
      @(posedge clk); #1;
      check($sformatf("toggle_%0d", k), io_out,
            pins(1'(k % 2), 1'((k - 1) % 2), 4'((k - 1) % 16)));
    end
    #2 rst_n = 1'b0;
    #1 check("reset_mid_run", io_out, pins(1'b0, 1'b0, 4'd0));
    @(posedge clk); #1;
    check("reset_mid_run_clk", io_out, pins(1'b0, 1'b0, 4'd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
